// File: rtl/bolme_sirali_if.sv
// Divider request/result bundle: start/operands in, results and status out.
interface bolme_sirali_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          done;
    logic          busy;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, done, busy, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, done, busy, div_by_zero
    );
endinterface

// File: rtl/bolme_sirali.sv
// Sequential restoring divider, one quotient bit per shift/subtract pair of clocks.
module bolme_sirali #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    bolme_sirali_if.slave   bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_SUB, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [VW:0]   r;
    logic [DW-1:0] q;
    logic [VW-1:0] d;
    logic [CW-1:0] count;
    logic [DW-1:0] quo;
    logic [VW-1:0] rem;
    logic          done_r;
    logic          dbz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = (bus.divisor == '0) ? S_DONE : S_SHIFT;
            S_SHIFT: state_nxt = S_SUB;
            S_SUB:   state_nxt = (count == LAST) ? S_DONE : S_SHIFT;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r      <= '0;
            q      <= '0;
            d      <= '0;
            count  <= '0;
            quo    <= '0;
            rem    <= '0;
            done_r <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        q     <= bus.dividend;
                        r     <= '0;
                        d     <= bus.divisor;
                        count <= '0;
                        dbz   <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    // MSB of Q moves into the LSB of the partial remainder
                    r <= {r[VW-1:0], q[DW-1]};
                    q <= {q[DW-2:0], 1'b0};
                end
                S_SUB: begin
                    if (r >= {1'b0, d}) begin
                        r    <= r - {1'b0, d};
                        q[0] <= 1'b1;
                    end
                    count <= count + CW'(1);
                end
                S_DONE: begin
                    done_r <= 1'b1;
                    if (d == '0) begin
                        quo <= '1;
                        rem <= '0;
                        dbz <= 1'b1;
                    end else begin
                        quo <= q;
                        rem <= r[VW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz;
    assign bus.busy        = (state != S_IDLE);
endmodule
